// File: rtl/change_dispense_ctrl_pkg.sv
// Shared types and coin constants for the change dispensing controller.
// All monetary amounts are expressed in nickel units.
package change_pkg;

    // Coin encodings double as their value in nickels.
    typedef enum logic [2:0] {
        COIN_NONE    = 3'd0,
        COIN_NICKEL  = 3'd1,
        COIN_DIME    = 3'd2,
        COIN_QUARTER = 3'd5
    } coin_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SELECT = 3'd2,
        ST_OFFER  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] QUARTER_VAL = 4'd5;
    localparam logic [3:0] DIME_VAL    = 4'd2;
    localparam logic [3:0] NICKEL_VAL  = 4'd1;

    // Value of a coin in nickels, widened to the change width.
    function automatic logic [3:0] coin_val(input coin_t c);
        case (c)
            COIN_QUARTER: return QUARTER_VAL;
            COIN_DIME:    return DIME_VAL;
            COIN_NICKEL:  return NICKEL_VAL;
            default:      return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispense_ctrl_coin_pick.sv
// Greedy coin selector: largest coin that fits the outstanding change
// and is still in stock. Purely combinational.
module coin_pick
    import change_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic [3:0]       change_i,
    input  logic [CNT_W-1:0] inv_q_i,
    input  logic [CNT_W-1:0] inv_d_i,
    input  logic [CNT_W-1:0] inv_n_i,
    output coin_t            coin_o
);

    // Priority chain quarter > dime > nickel; a coin is only eligible if in stock.
    always_comb begin
        coin_o = COIN_NONE;
        if (change_i >= QUARTER_VAL && inv_q_i != '0) begin
            coin_o = COIN_QUARTER;
        end else if (change_i >= DIME_VAL && inv_d_i != '0) begin
            coin_o = COIN_DIME;
        end else if (change_i >= NICKEL_VAL && inv_n_i != '0) begin
            coin_o = COIN_NICKEL;
        end
    end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change-making sequencer: captures cost/paid, then dispenses change one
// coin at a time from a tracked quarter/dime/nickel inventory over a
// valid/ready handshake to an external dispenser.
module change_dispense_ctrl
    import change_pkg::*;
#(
    parameter int CNT_W     = 2,
    parameter int MAX_COINS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       cost,
    input  logic [3:0]       paid,
    input  logic             refill,
    input  logic [CNT_W-1:0] refill_q,
    input  logic [CNT_W-1:0] refill_d,
    input  logic [CNT_W-1:0] refill_n,
    output logic             disp_valid,
    output logic [2:0]       disp_coin,
    input  logic             disp_ready,
    output logic             busy,
    output logic             done,
    output logic             exact_amount,
    output logic             cough_up_more,
    output logic             short_change,
    output logic [3:0]       remaining,
    output logic [2:0]       coins_given,
    output logic [CNT_W-1:0] inv_q,
    output logic [CNT_W-1:0] inv_d,
    output logic [CNT_W-1:0] inv_n
);

    localparam logic [2:0]       MAX_C   = 3'(MAX_COINS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    logic [3:0]       cost_q;
    logic [3:0]       paid_q;
    logic [3:0]       change_q;
    logic             disp_valid_q;
    coin_t            disp_coin_q;
    logic             done_q;
    logic             exact_q;
    logic             cough_q;
    logic             short_q;
    logic [3:0]       remaining_q;
    logic [2:0]       coins_q;
    logic [CNT_W-1:0] qtr_cnt_q;
    logic [CNT_W-1:0] dime_cnt_q;
    logic [CNT_W-1:0] nick_cnt_q;
    coin_t            pick;

    // Refill addition done one bit wider so an overflow clamps to full scale.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[CNT_W]) begin
            return '1;
        end
        return sum[CNT_W-1:0];
    endfunction

    coin_pick #(
        .CNT_W (CNT_W)
    ) u_coin_pick (
        .change_i (change_q),
        .inv_q_i  (qtr_cnt_q),
        .inv_d_i  (dime_cnt_q),
        .inv_n_i  (nick_cnt_q),
        .coin_o   (pick)
    );

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cost_q       <= '0;
            paid_q       <= '0;
            change_q     <= '0;
            disp_valid_q <= 1'b0;
            disp_coin_q  <= COIN_NONE;
            done_q       <= 1'b0;
            exact_q      <= 1'b0;
            cough_q      <= 1'b0;
            short_q      <= 1'b0;
            remaining_q  <= '0;
            coins_q      <= '0;
            qtr_cnt_q    <= '0;
            dime_cnt_q   <= '0;
            nick_cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        // start wins over a simultaneous refill
                        cost_q      <= cost;
                        paid_q      <= paid;
                        change_q    <= '0;
                        exact_q     <= 1'b0;
                        cough_q     <= 1'b0;
                        short_q     <= 1'b0;
                        remaining_q <= '0;
                        coins_q     <= '0;
                        state_q     <= ST_CHECK;
                    end else if (refill) begin
                        qtr_cnt_q  <= sat_add(qtr_cnt_q, refill_q);
                        dime_cnt_q <= sat_add(dime_cnt_q, refill_d);
                        nick_cnt_q <= sat_add(nick_cnt_q, refill_n);
                    end
                end
                ST_CHECK: begin
                    if (paid_q < cost_q) begin
                        cough_q     <= 1'b1;
                        change_q    <= '0;
                        remaining_q <= '0;
                        done_q      <= 1'b1;
                        state_q     <= ST_DONE;
                    end else if (paid_q == cost_q) begin
                        exact_q     <= 1'b1;
                        change_q    <= '0;
                        remaining_q <= '0;
                        done_q      <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        change_q <= paid_q - cost_q;
                        state_q  <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (change_q == '0 || pick == COIN_NONE || coins_q == MAX_C) begin
                        // results are published as DONE is entered so they
                        // coincide with the done pulse
                        remaining_q <= change_q;
                        short_q     <= (change_q != '0);
                        done_q      <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        disp_coin_q  <= pick;
                        disp_valid_q <= 1'b1;
                        state_q      <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (disp_ready) begin
                        disp_valid_q <= 1'b0;
                        disp_coin_q  <= COIN_NONE;
                        change_q     <= change_q - coin_val(disp_coin_q);
                        coins_q      <= coins_q + 3'd1;
                        case (disp_coin_q)
                            COIN_QUARTER: qtr_cnt_q  <= qtr_cnt_q - CNT_ONE;
                            COIN_DIME:    dime_cnt_q <= dime_cnt_q - CNT_ONE;
                            COIN_NICKEL:  nick_cnt_q <= nick_cnt_q - CNT_ONE;
                            default:      ;
                        endcase
                        state_q <= ST_SELECT;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign disp_valid    = disp_valid_q;
    assign disp_coin     = disp_coin_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign exact_amount  = exact_q;
    assign cough_up_more = cough_q;
    assign short_change  = short_q;
    assign remaining     = remaining_q;
    assign coins_given   = coins_q;
    assign inv_q         = qtr_cnt_q;
    assign inv_d         = dime_cnt_q;
    assign inv_n         = nick_cnt_q;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Testbench for change_dispense_ctrl: directed vector table, hand-written
// corner sequences, and randomized transactions against a greedy model.
module tb_change_dispense_ctrl;

    localparam int CNT_W     = 2;
    localparam int MAX_COINS = 4;
    localparam int CMAX      = 3;

    logic             clock;
    logic             reset;
    logic             start;
    logic [3:0]       cost;
    logic [3:0]       paid;
    logic             refill;
    logic [CNT_W-1:0] refill_q;
    logic [CNT_W-1:0] refill_d;
    logic [CNT_W-1:0] refill_n;
    logic             disp_valid;
    logic [2:0]       disp_coin;
    logic             disp_ready;
    logic             busy;
    logic             done;
    logic             exact_amount;
    logic             cough_up_more;
    logic             short_change;
    logic [3:0]       remaining;
    logic [2:0]       coins_given;
    logic [CNT_W-1:0] inv_q;
    logic [CNT_W-1:0] inv_d;
    logic [CNT_W-1:0] inv_n;

    change_dispense_ctrl #(
        .CNT_W     (CNT_W),
        .MAX_COINS (MAX_COINS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .cost          (cost),
        .paid          (paid),
        .refill        (refill),
        .refill_q      (refill_q),
        .refill_d      (refill_d),
        .refill_n      (refill_n),
        .disp_valid    (disp_valid),
        .disp_coin     (disp_coin),
        .disp_ready    (disp_ready),
        .busy          (busy),
        .done          (done),
        .exact_amount  (exact_amount),
        .cough_up_more (cough_up_more),
        .short_change  (short_change),
        .remaining     (remaining),
        .coins_given   (coins_given),
        .inv_q         (inv_q),
        .inv_d         (inv_d),
        .inv_n         (inv_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int pk(input int a, input int b, input int c, input int d);
        return a | (b << 3) | (c << 6) | (d << 9);
    endfunction

    // ---------------- reference model (transaction level) ----------------
    int m_q, m_d, m_n;
    int m_cnt, m_coins, m_rem, m_ex, m_cu, m_sh;

    task automatic model_reset();
        m_q = 0; m_d = 0; m_n = 0;
    endtask

    task automatic model_refill(input int a, input int b, input int c);
        m_q = (m_q + a > CMAX) ? CMAX : m_q + a;
        m_d = (m_d + b > CMAX) ? CMAX : m_d + b;
        m_n = (m_n + c > CMAX) ? CMAX : m_n + c;
    endtask

    task automatic model_txn(input int cost_v, input int paid_v);
        int vals[3];
        int stock[3];
        int change;
        int pick;
        vals  = '{5, 2, 1};
        stock = '{m_q, m_d, m_n};
        m_ex    = (paid_v == cost_v) ? 1 : 0;
        m_cu    = (paid_v < cost_v) ? 1 : 0;
        change  = (paid_v > cost_v) ? paid_v - cost_v : 0;
        m_cnt   = 0;
        m_coins = 0;
        while (change > 0 && m_cnt < MAX_COINS) begin
            pick = -1;
            for (int k = 0; k < 3; k++) begin
                if (pick < 0 && vals[k] <= change && stock[k] > 0) pick = k;
            end
            if (pick < 0) break;
            stock[pick]--;
            change  -= vals[pick];
            m_coins |= vals[pick] << (3 * m_cnt);
            m_cnt++;
        end
        m_rem = change;
        m_sh  = (change != 0) ? 1 : 0;
        m_q = stock[0]; m_d = stock[1]; m_n = stock[2];
    endtask

    // ---------------- stimulus helpers ----------------
    int o_coins[16];
    int o_n, o_lat, o_held;

    task automatic do_refill(input int a, input int b, input int c);
        refill   = 1'b1;
        refill_q = CNT_W'(a);
        refill_d = CNT_W'(b);
        refill_n = CNT_W'(c);
        tick();
        refill   = 1'b0;
        refill_q = '0;
        refill_d = '0;
        refill_n = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // mode 0: ready high, 1: random ready, 2: ready low for 5 offered cycles
    task automatic run_txn(input int cost_v, input int paid_v, input int mode);
        int prev_v, prev_c, prev_hs, prev_inv, r, hs;
        start = 1'b1;
        cost  = 4'(cost_v);
        paid  = 4'(paid_v);
        tick();
        start   = 1'b0;
        o_n     = 0;
        o_lat   = 1;
        o_held  = 0;
        prev_v  = 0;
        prev_c  = 0;
        prev_hs = 1;
        prev_inv = 0;
        while (!done && o_lat < 300) begin
            if (prev_v != 0 && prev_hs == 0) begin
                chk("offer_hold_valid", int'(disp_valid), 1);
                chk("offer_hold_coin", int'(disp_coin), prev_c);
                chk("offer_hold_inv", int'({inv_q, inv_d, inv_n}), prev_inv);
            end
            case (mode)
                0:       r = 1;
                1:       r = int'($urandom_range(0, 1));
                default: r = (o_held >= 5) ? 1 : 0;
            endcase
            if (disp_valid && r == 0) o_held++;
            disp_ready = (r != 0);
            hs = (disp_valid && r != 0) ? 1 : 0;
            if (hs != 0) begin
                if (o_n < 16) o_coins[o_n] = int'(disp_coin);
                o_n++;
            end
            prev_v   = int'(disp_valid);
            prev_c   = int'(disp_coin);
            prev_hs  = hs;
            prev_inv = int'({inv_q, inv_d, inv_n});
            tick();
            o_lat++;
        end
        disp_ready = 1'b0;
        if (!done) chk("txn_timeout", 0, 1);
    endtask

    task automatic check_result(input string tag, input int exp_n, input int exp_coins,
                                input int exp_rem, input int eq, input int ed, input int en,
                                input int ex, input int cu, input int sh);
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_busy_in_done"}, int'(busy), 1);
        chk({tag, "_handshakes"}, o_n, exp_n);
        chk({tag, "_coins_given"}, int'(coins_given), exp_n);
        for (int i = 0; i < exp_n && i < o_n; i++) begin
            chk({tag, "_coin"}, o_coins[i], (exp_coins >> (3 * i)) & 7);
        end
        chk({tag, "_remaining"}, int'(remaining), exp_rem);
        chk({tag, "_exact"}, int'(exact_amount), ex);
        chk({tag, "_cough"}, int'(cough_up_more), cu);
        chk({tag, "_short"}, int'(short_change), sh);
        chk({tag, "_inv_q"}, int'(inv_q), eq);
        chk({tag, "_inv_d"}, int'(inv_d), ed);
        chk({tag, "_inv_n"}, int'(inv_n), en);
        tick();
        chk({tag, "_done_pulse"}, int'(done), 0);
        chk({tag, "_idle"}, int'(busy), 0);
        chk({tag, "_remaining_hold"}, int'(remaining), exp_rem);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, int'(disp_valid), 0);
        chk({tag, "_coin"}, int'(disp_coin), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_exact"}, int'(exact_amount), 0);
        chk({tag, "_cough"}, int'(cough_up_more), 0);
        chk({tag, "_short"}, int'(short_change), 0);
        chk({tag, "_remaining"}, int'(remaining), 0);
        chk({tag, "_coins_given"}, int'(coins_given), 0);
        chk({tag, "_inv"}, int'({inv_q, inv_d, inv_n}), 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int do_refill, rq, rd, rn;
        int cost, paid, mode, lat;
        int n, coins, rem, iq, id, in_;
        int ex, cu, sh;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int wait_cnt;
        int c_v, p_v;

        reset = 1'b1; start = 1'b0; cost = '0; paid = '0;
        refill = 1'b0; refill_q = '0; refill_d = '0; refill_n = '0;
        disp_ready = 1'b0;

        vecs[0] = '{1, 1, 3, 3,  3, 12, 0, 9,  3, pk(5, 2, 2, 0), 0, 0, 1, 3,  0, 0, 0};
        vecs[1] = '{0, 0, 0, 0,  7,  7, 0, 2,  0, 0,               0, 0, 1, 3,  1, 0, 0};
        vecs[2] = '{0, 0, 0, 0,  9,  4, 1, 2,  0, 0,               0, 0, 1, 3,  0, 1, 0};
        vecs[3] = '{1, 3, 3, 3,  0, 15, 1, 0,  3, pk(5, 5, 5, 0), 0, 0, 3, 3,  0, 0, 0};
        vecs[4] = '{0, 0, 0, 0,  0, 15, 1, 0,  4, pk(2, 2, 2, 1), 8, 0, 0, 2,  0, 0, 1};
        vecs[5] = '{0, 0, 0, 0,  2,  5, 0, 0,  2, pk(1, 1, 0, 0), 1, 0, 0, 0,  0, 0, 1};
        vecs[6] = '{1, 0, 0, 1,  0,  4, 0, 5,  1, pk(1, 0, 0, 0), 3, 0, 0, 0,  0, 0, 1};
        vecs[7] = '{0, 0, 0, 0,  1,  2, 1, 0,  0, 0,               1, 0, 0, 0,  0, 0, 1};
        vecs[8] = '{1, 1, 0, 0,  0,  5, 2, 0,  1, pk(5, 0, 0, 0), 0, 0, 0, 0,  0, 0, 0};

        // reset state
        tick();
        tick();
        reset = 1'b0;
        check_all_zero("reset");

        // refill saturation
        do_refill(3, 3, 3);
        chk("refill1_inv", int'({inv_q, inv_d, inv_n}), 6'b11_11_11);
        do_refill(3, 3, 3);
        chk("refill2_sat_q", int'(inv_q), 3);
        chk("refill2_sat_d", int'(inv_d), 3);
        chk("refill2_sat_n", int'(inv_n), 3);

        // start and refill in the same cycle: refill ignored
        do_reset();
        start = 1'b1; cost = 4'd5; paid = 4'd5;
        refill = 1'b1; refill_q = 2'd3; refill_d = 2'd3; refill_n = 2'd3;
        tick();
        start = 1'b0; refill = 1'b0; refill_q = '0; refill_d = '0; refill_n = '0;
        wait_cnt = 0;
        while (!done && wait_cnt < 10) begin
            tick();
            wait_cnt++;
        end
        chk("start_refill_done", int'(done), 1);
        chk("start_refill_exact", int'(exact_amount), 1);
        chk("start_refill_inv", int'({inv_q, inv_d, inv_n}), 0);
        tick();

        // vector table from a clean inventory
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_refill != 0) do_refill(vecs[i].rq, vecs[i].rd, vecs[i].rn);
            run_txn(vecs[i].cost, vecs[i].paid, vecs[i].mode);
            if (vecs[i].lat != 0) chk($sformatf("vec%0d_latency", i), o_lat, vecs[i].lat);
            if (vecs[i].mode == 2) chk($sformatf("vec%0d_held_cycles", i), o_held, 5);
            check_result($sformatf("vec%0d", i), vecs[i].n, vecs[i].coins, vecs[i].rem,
                         vecs[i].iq, vecs[i].id, vecs[i].in_,
                         vecs[i].ex, vecs[i].cu, vecs[i].sh);
        end

        // reset while a coin is being offered
        do_reset();
        do_refill(1, 1, 1);
        start = 1'b1; cost = 4'd0; paid = 4'd5;
        tick();
        start = 1'b0;
        disp_ready = 1'b0;
        wait_cnt = 0;
        while (!disp_valid && wait_cnt < 10) begin
            tick();
            wait_cnt++;
        end
        chk("mid_offer_reached", int'(disp_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("mid_offer_reset");
        tick();
        check_all_zero("mid_offer_after");

        // randomized transactions against the model
        model_reset();
        for (int t = 0; t < 120; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                int a, b, c;
                a = int'($urandom_range(0, 3));
                b = int'($urandom_range(0, 3));
                c = int'($urandom_range(0, 3));
                do_refill(a, b, c);
                model_refill(a, b, c);
            end
            p_v = int'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) c_v = int'($urandom_range(0, 15));
            else c_v = int'($urandom_range(0, p_v));
            run_txn(c_v, p_v, int'($urandom_range(0, 1)));
            model_txn(c_v, p_v);
            check_result("rnd", m_cnt, m_coins, m_rem, m_q, m_d, m_n, m_ex, m_cu, m_sh);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
